// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the decode handshake.
// master = fetch controller, slave = memory/decode side.
interface pc_fetch_ctrl_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrValid;
  logic        instrReady;

  modport master (
    output imemReq, imemAddr, instr, instrPc, instrValid,
    input  imemReady, imemRvalid, imemRdata, instrReady
  );

  modport slave (
    input  imemReq, imemAddr, instr, instrPc, instrValid,
    output imemReady, imemRvalid, imemRdata, instrReady
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Flow-controlled instruction-fetch front end: owns the PC, issues one fetch at a time,
// holds each instruction for decode. Optional macro FETCH_MISALIGN_CHECK_EN halts on misaligned redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcSrc,
  input  logic [31:0] pcTarget,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] pcNext,
  output logic        misalignErr,
  pc_fetch_ctrl_if.master bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              discard_q, discard_d;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
  assign misalignErr = misalign_q;
`else
  assign misalignErr = 1'b0;
`endif

  assign pc             = pc_q;
  assign pcPlus4        = pc_q + XLEN'(4);
  assign pcNext         = pcSrc ? pcTarget : pcPlus4;
  assign bus.imemReq    = (state_q == S_REQ) && !reset;
  assign bus.imemAddr   = pc_q;
  assign bus.instr      = instr_q;
  assign bus.instrPc    = instr_pc_q;
  assign bus.instrValid = instr_valid_q;

  // Next-state and datapath; a redirect pre-empts every other event.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    discard_d     = discard_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d    = misalign_q;
`endif

    if (pcSrc && (state_q != S_HALT)) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (pcTarget[1:0] != 2'b00) begin
        misalign_d    = 1'b1;
        instr_valid_d = 1'b0;
        state_d       = S_HALT;
      end else
`endif
      begin
        pc_d = pcTarget & ~XLEN'(3);
        case (state_q)
          S_REQ: begin
            // The old-address request is already in flight; its response must be dropped.
            if (bus.imemReady) begin
              state_d   = S_WAIT;
              discard_d = 1'b1;
            end
          end
          S_WAIT: begin
            if (bus.imemRvalid) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              discard_d = 1'b1;
            end
          end
          S_HOLD: begin
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
          end
          default: ;
        endcase
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.imemReady) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.imemRvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              instr_d       = bus.imemRdata;
              instr_pc_d    = pc_q;
              instr_valid_d = 1'b1;
              state_d       = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.instrReady) begin
            pc_d          = pcPlus4;
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      discard_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      discard_q     <= discard_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Instruction-fetch controller that owns the program counter and drives the instruction memory. It performs the next-PC selection internally: sequential `pc + 4`, or a redirect target from the execute stage. It presents each fetched instruction with its PC to decode over a valid/ready handshake. It sits between the branch/jump resolution logic (`pcSrc`, `pcTarget`) and the instruction memory, and replaces a free-running PC register with a flow-controlled fetch front end.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `pcSrc`  in  1: redirect request, sampled every cycle.
- `pcTarget`  in  32: redirect target, valid when `pcSrc` = 1.
- `imemReq`  out  1: fetch request valid.
- `imemAddr`  out  32: fetch address; equals `pc` while `imemReq` = 1.
- `imemReady`  in  1: memory accepts the request when `imemReq && imemReady`.
- `imemRvalid`  in  1: read data valid; exactly one pulse per accepted request, no earlier than the cycle after acceptance.
- `imemRdata`  in  32: instruction word.
- `instr`  out  32: held instruction to decode.
- `instrPc`  out  32: PC of `instr`.
- `instrValid`  out  1: `instr` and `instrPc` valid.
- `instrReady`  in  1: decode consumes when `instrValid && instrReady`.
- `pc`  out  32: current fetch PC register.
- `pcPlus4`  out  32: `pc + 4`, modulo 2^32.
- `pcNext`  out  32: `pcSrc ? pcTarget : pcPlus4`, combinational.
- `misalignErr`  out  1: sticky misaligned-target flag.

## Operation
- States: `S_REQ`, `S_WAIT`, `S_HOLD`, `S_HALT`.
- Reset values: state `S_REQ`, `pc` = `RESET_PC`, `instr` = 0, `instrPc` = 0, `instrValid` = 0, `misalignErr` = 0, discard flag = 0.
- `imemReq` = 1 only in `S_REQ` and only when not in reset.
- `S_REQ`: on acceptance, go to `S_WAIT`.
- `S_WAIT`: on `imemRvalid`:
  - If the discard flag is set, clear it and go to `S_REQ`.
  - Otherwise latch `instr` = `imemRdata` and `instrPc` = `pc`, set `instrValid`, and go to `S_HOLD`.
- `S_HOLD`: on the decode handshake, set `pc` = `pcPlus4`, clear `instrValid`, and go to `S_REQ`.
- A redirect (`pcSrc` = 1 in any state except `S_HALT`) always loads `pc` = `pcTarget`. It takes priority over every other event:
  - In `S_REQ` with the request accepted the same cycle: go to `S_WAIT` and set discard, because the old-address response must be dropped.
  - In `S_REQ` without acceptance: stay in `S_REQ`.
  - In `S_WAIT`: set discard and stay. If `imemRvalid` arrives the same cycle, drop it and go to `S_REQ`.
  - In `S_HOLD`: clear `instrValid` and go to `S_REQ`. The held instruction is dropped even if `instrReady` = 1 that cycle.
- `S_HALT`: terminal state. `imemReq` = 0, `instrValid` = 0, and `pc` is frozen. Only `reset` exits it.
- Arithmetic: 32-bit adds with wrap-around, so `pc` = `32'hFFFF_FFFC` gives `pcPlus4` = 0. No carry out.
- Reset asserted mid-transaction returns every register to its reset value. Any `imemRvalid` arriving after reset release for a pre-reset request is a memory-side protocol violation; the block does not filter it.

## Timing
- First `imemReq` is in the first cycle after `reset` deasserts, with `imemAddr` = `RESET_PC`.
- With `imemReady` = 1, response latency 1 and `instrReady` = 1, the block delivers one instruction every 3 cycles (REQ, WAIT, HOLD).
- `instrValid` rises the cycle after `imemRvalid` and stays high until the handshake or a redirect.
- A redirect is visible on `pc` and `imemAddr` one cycle after `pcSrc`.
- `pcNext` and `pcPlus4` are zero-latency combinational outputs.

## Configuration
- Macro: `FETCH_MISALIGN_CHECK_EN`.
- Defined:
  - A redirect with `pcTarget[1:0]` != 0 sets `misalignErr` and goes to `S_HALT` instead of loading `pc`.
  - The same-cycle `imemRvalid` is ignored.
- Undefined:
  - `misalignErr` is tied to 0 and `S_HALT` is unreachable.
  - `pcTarget` is loaded with bits [1:0] forced to 0.

## Test plan
- Reset release with `RESET_PC` = `32'h100`, memory latency 1, `instrReady` = 1 -> `imemAddr` sequence `100, 104, 108`, one `instrValid` pulse per 3 cycles, `instrPc` matching each address.
- `instrReady` held at 0 for 5 cycles in `S_HOLD` -> `instrValid`, `instr` and `instrPc` stable; no new `imemReq`; `pc` unchanged.
- `pcSrc` = 1 with `pcTarget` = `32'h200` while in `S_WAIT` -> the in-flight response is dropped (no `instrValid`), next `imemAddr` = `200`.
- `pcSrc` coincident with `instrReady` in `S_HOLD`, target `32'h40` -> held instruction not consumed, `instrValid` falls, next fetch at `40`.
- `pc` = `32'hFFFF_FFFC` and consume -> next `imemAddr` = `0`.
- With `FETCH_MISALIGN_CHECK_EN`, `pcTarget` = `32'h202` -> `misalignErr` = 1, `imemReq` = 0 permanently until `reset`. Without the macro -> fetch at `200`.
